regfile_mp: RTL and testbench

//  Multi-port architectural register file for the Tomasulo core; successor to the single-CDB file.

---
 rtl/cobalt_pkg.sv | 20 ++
 rtl/regfile_wr_arb.sv | 63 ++++++
 rtl/regfile_mp.sv | 149 ++++++++++++++
 tb/tb_regfile_mp.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobalt_pkg.sv
// +--------------------------------------------------------------------------+
// | Module  : cobalt_pkg                                                     |
// | Brief   : Shared defaults and dump FSM state type for the register file. |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package cobalt_pkg;

  localparam int c_W_DATA_DEFAULT = 32;
  localparam int c_W_ADDR_DEFAULT = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wr_arb.sv
// +--------------------------------------------------------------------------+
// | Module  : regfile_wr_arb                                                 |
// | Brief   : Per-entry lowest-port-wins write select and conflict detection |
// |           over N_WPORT one-hot CDB write vectors (combinational).        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_wr_arb #(
  parameter int W_DATA  = 32,
  parameter int N_ENTRY = 32,
  parameter int N_WPORT = 2
) (
  input  logic [N_WPORT*N_ENTRY-1:0] wen_onehot,
  input  logic [N_WPORT*W_DATA-1:0]  wdata,
  output logic [N_ENTRY-1:0]         ent_we,
  output logic [N_ENTRY*W_DATA-1:0]  ent_wdata,
  output logic                       conflict
);

  logic [N_WPORT-1:0] w_port_multi;
  logic [N_ENTRY-1:0] w_ent_multi;

  // A vector with more than one bit set leaves a non-zero residue after v & (v-1).
  generate
    for (genvar p = 0; p < N_WPORT; p++) begin : g_port
      logic [N_ENTRY-1:0] w_vec;
      assign w_vec           = wen_onehot[p*N_ENTRY +: N_ENTRY];
      assign w_port_multi[p] = |(w_vec & (w_vec - N_ENTRY'(1)));
    end
  endgenerate

  generate
    for (genvar e = 0; e < N_ENTRY; e++) begin : g_ent
      logic              w_seen;
      logic              w_multi;
      logic [W_DATA-1:0] w_data;

      // Scan high to low so the lowest requesting port is the last to overwrite w_data.
      always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_data  = '0;
        for (int p = N_WPORT - 1; p >= 0; p--) begin
          if (wen_onehot[p*N_ENTRY + e]) begin
            if (w_seen) w_multi = 1'b1;
            w_seen = 1'b1;
            w_data = wdata[p*W_DATA +: W_DATA];
          end
        end
      end

      assign ent_we[e]                      = w_seen;
      assign ent_wdata[e*W_DATA +: W_DATA]  = w_data;
      assign w_ent_multi[e]                 = w_multi;
    end
  endgenerate

  assign conflict = (|w_port_multi) | (|w_ent_multi);

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// +--------------------------------------------------------------------------+
// | Module  : regfile_mp                                                     |
// | Brief   : Multi-port architectural register file: N_WPORT CDB writes,    |
// |           N_RPORT combinational reads, valid/ready full-file dump.       |
// |           Define REGFILE_BYPASS_EN for same-cycle CDB write-through.     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_mp
  import cobalt_pkg::*;
#(
  parameter  int W_DATA   = c_W_DATA_DEFAULT,
  parameter  int W_ADDR   = c_W_ADDR_DEFAULT,
  parameter  int N_WPORT  = 2,
  parameter  int N_RPORT  = 4,
  parameter  int ZERO_R0  = 1,
  parameter  int INIT_IDX = 0,
  localparam int N_ENTRY  = 2**W_ADDR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_WPORT*N_ENTRY-1:0] wen_onehot,
  input  logic [N_WPORT*W_DATA-1:0]  wdata,
  input  logic [N_RPORT*W_ADDR-1:0]  raddr,
  output logic [N_RPORT*W_DATA-1:0]  rdata,
  input  logic                       dump_start,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [W_ADDR-1:0]          dump_addr,
  output logic [W_DATA-1:0]          dump_data,
  output logic                       dump_last,
  output logic                       dump_busy,
  output logic                       err_wconf
);

  localparam logic [W_ADDR-1:0] c_LAST_ADDR = W_ADDR'(N_ENTRY - 1);

  logic [W_DATA-1:0]         r_mem [N_ENTRY];
  logic [N_ENTRY-1:0]        w_ent_we;
  logic [N_ENTRY*W_DATA-1:0] w_ent_wdata;
  logic                      w_conflict;
  logic                      r_err_wconf;
  dump_state_t               r_state;
  logic [W_ADDR-1:0]         r_dump_addr;
  logic                      r_dump_valid;
  logic                      r_dump_last;

  regfile_wr_arb #(
    .W_DATA  (W_DATA),
    .N_ENTRY (N_ENTRY),
    .N_WPORT (N_WPORT)
  ) u_wr_arb (
    .wen_onehot (wen_onehot),
    .wdata      (wdata),
    .ent_we     (w_ent_we),
    .ent_wdata  (w_ent_wdata),
    .conflict   (w_conflict)
  );

  // Storage; entry 0 never takes a write when hardwired to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < N_ENTRY; e++) begin
        r_mem[e] <= (INIT_IDX != 0) ? W_DATA'(e) : '0;
      end
    end else begin
      for (int e = 0; e < N_ENTRY; e++) begin
        if (w_ent_we[e] && !((ZERO_R0 != 0) && (e == 0))) begin
          r_mem[e] <= w_ent_wdata[e*W_DATA +: W_DATA];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_wconf <= 1'b0;
    end else if (w_conflict) begin
      r_err_wconf <= 1'b1;
    end
  end

  function automatic logic [W_DATA-1:0] read_ent(input logic [W_ADDR-1:0] addr);
    logic [W_DATA-1:0] val;
    val = r_mem[addr];
`ifdef REGFILE_BYPASS_EN
    if (w_ent_we[addr]) val = w_ent_wdata[addr*W_DATA +: W_DATA];
`endif
    if ((ZERO_R0 != 0) && (addr == '0)) val = '0;
    return val;
  endfunction

  generate
    for (genvar k = 0; k < N_RPORT; k++) begin : g_rd
      assign rdata[k*W_DATA +: W_DATA] = read_ent(raddr[k*W_ADDR +: W_ADDR]);
    end
  endgenerate

  // Dump FSM: valid/last are registered alongside the state so they drop with reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_dump_addr  <= '0;
      r_dump_valid <= 1'b0;
      r_dump_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dump_start) begin
            r_state      <= RUN;
            r_dump_addr  <= '0;
            r_dump_valid <= 1'b1;
            r_dump_last  <= (c_LAST_ADDR == '0);
          end
        end
        RUN: begin
          if (dump_ready) begin
            if (r_dump_addr == c_LAST_ADDR) begin
              r_state      <= IDLE;
              r_dump_addr  <= '0;
              r_dump_valid <= 1'b0;
              r_dump_last  <= 1'b0;
            end else begin
              r_dump_addr  <= r_dump_addr + W_ADDR'(1);
              r_dump_last  <= ((r_dump_addr + W_ADDR'(1)) == c_LAST_ADDR);
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_dump_addr  <= '0;
          r_dump_valid <= 1'b0;
          r_dump_last  <= 1'b0;
        end
      endcase
    end
  end

  assign dump_valid = r_dump_valid;
  assign dump_addr  = r_dump_addr;
  assign dump_last  = r_dump_last;
  assign dump_busy  = (r_state != IDLE);
  assign dump_data  = read_ent(r_dump_addr);
  assign err_wconf  = r_err_wconf;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_regfile_mp                                                  |
// | Brief   : Directed + randomized bench for regfile_mp against an array    |
// |           reference model.                                               |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_mp;

  localparam int W_DATA  = 32;
  localparam int W_ADDR  = 5;
  localparam int N_ENTRY = 32;
  localparam int N_WPORT = 2;
  localparam int N_RPORT = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [N_WPORT*N_ENTRY-1:0] wen_onehot;
  logic [N_WPORT*W_DATA-1:0]  wdata;
  logic [N_RPORT*W_ADDR-1:0]  raddr;
  logic [N_RPORT*W_DATA-1:0]  rdata;
  logic                       dump_start;
  logic                       dump_valid;
  logic                       dump_ready;
  logic [W_ADDR-1:0]          dump_addr;
  logic [W_DATA-1:0]          dump_data;
  logic                       dump_last;
  logic                       dump_busy;
  logic                       err_wconf;

  always #5 clk = ~clk;

  regfile_mp #(
    .W_DATA   (W_DATA),
    .W_ADDR   (W_ADDR),
    .N_WPORT  (N_WPORT),
    .N_RPORT  (N_RPORT),
    .ZERO_R0  (1),
    .INIT_IDX (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wen_onehot (wen_onehot),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .dump_busy  (dump_busy),
    .err_wconf  (err_wconf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array contents, sticky error flag, dump cursor.
  logic [W_DATA-1:0] m_mem [N_ENTRY];
  bit                m_err;
  bit                m_busy;
  int                m_addr;
  int                beat_addr [$];
  bit                beat_last [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_ENTRY; i++) m_mem[i] = W_DATA'(i);
    m_err  = 1'b0;
    m_busy = 1'b0;
    m_addr = 0;
  endtask

  function automatic logic [W_DATA-1:0] exp_read(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < N_WPORT; p++)
      if (wen_onehot[p*N_ENTRY + a]) return wdata[p*W_DATA +: W_DATA];
`endif
    return m_mem[a];
  endfunction

  task automatic clear_inputs();
    wen_onehot = '0;
    wdata      = '0;
    raddr      = '0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
  endtask

  task automatic set_raddr(input int a0, input int a1, input int a2, input int a3);
    raddr = {W_ADDR'(a3), W_ADDR'(a2), W_ADDR'(a1), W_ADDR'(a0)};
  endtask

  task automatic set_write(input int p, input int e, input logic [W_DATA-1:0] d);
    wen_onehot[p*N_ENTRY + e]   = 1'b1;
    wdata[p*W_DATA +: W_DATA]   = d;
  endtask

  // Called just after a falling edge with inputs driven: checks, clocks, updates model.
  task automatic step();
    int cnt;
    bit found;
    #1;
    for (int k = 0; k < N_RPORT; k++)
      check($sformatf("rdata%0d", k), rdata[k*W_DATA +: W_DATA],
            exp_read(int'(raddr[k*W_ADDR +: W_ADDR])));
    check("dump_valid", 32'(dump_valid), 32'(m_busy));
    check("dump_busy",  32'(dump_busy),  32'(m_busy));
    check("dump_addr",  32'(dump_addr),  32'(m_addr));
    check("dump_last",  32'(dump_last),  32'(m_busy && m_addr == N_ENTRY - 1));
    if (m_busy) check("dump_data", dump_data, exp_read(m_addr));
    check("err_wconf", 32'(err_wconf), 32'(m_err));
    if (dump_valid && dump_ready) begin
      beat_addr.push_back(int'(dump_addr));
      beat_last.push_back(dump_last);
    end
    @(posedge clk);
    for (int p = 0; p < N_WPORT; p++)
      if ($countones(wen_onehot[p*N_ENTRY +: N_ENTRY]) > 1) m_err = 1'b1;
    for (int e = 0; e < N_ENTRY; e++) begin
      cnt   = 0;
      found = 1'b0;
      for (int p = 0; p < N_WPORT; p++) begin
        if (wen_onehot[p*N_ENTRY + e]) begin
          cnt++;
          if (!found && e != 0) m_mem[e] = wdata[p*W_DATA +: W_DATA];
          found = 1'b1;
        end
      end
      if (cnt > 1) m_err = 1'b1;
    end
    if (m_busy) begin
      if (dump_ready) begin
        if (m_addr == N_ENTRY - 1) begin
          m_busy = 1'b0;
          m_addr = 0;
        end else begin
          m_addr++;
        end
      end
    end else if (dump_start) begin
      m_busy = 1'b1;
      m_addr = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit done;
    int r;
    logic [N_ENTRY-1:0] v;

    reset = 1'b0;
    clear_inputs();
    do_reset();

    // Reset values with index-initialised entries
    set_raddr(1, 2, 31, 0);
    #1;
    check("t1_rd_e1",  rdata[31:0],   32'd1);
    check("t1_rd_e2",  rdata[63:32],  32'd2);
    check("t1_rd_e31", rdata[95:64],  32'd31);
    check("t1_rd_e0",  rdata[127:96], 32'd0);
    check("t1_err",    32'(err_wconf), 32'd0);
    check("t1_busy",   32'(dump_busy), 32'd0);
    step();

    // Two ports, two distinct entries
    clear_inputs();
    set_write(0, 5, 32'hDEAD);
    set_write(1, 9, 32'hBEEF);
    step();
    clear_inputs();
    set_raddr(5, 9, 0, 0);
    #1;
    check("t2_rd_e5", rdata[31:0],  32'hDEAD);
    check("t2_rd_e9", rdata[63:32], 32'hBEEF);
    check("t2_err",   32'(err_wconf), 32'd0);
    step();

    // Same entry from both ports: lowest port wins, error becomes sticky
    clear_inputs();
    set_write(0, 7, 32'h11);
    set_write(1, 7, 32'h22);
    set_raddr(7, 7, 7, 7);
    step();
    clear_inputs();
    set_raddr(7, 0, 0, 0);
    #1;
    check("t3_rd_e7", rdata[31:0], 32'h11);
    check("t3_err",   32'(err_wconf), 32'd1);
    repeat (3) step();
    check("t3_err_sticky", 32'(err_wconf), 32'd1);

    // Entry 0 hardwired to zero, including the write cycle itself
    clear_inputs();
    set_write(0, 0, 32'hFFFF);
    set_raddr(0, 0, 0, 0);
    #1;
    check("t4_rd_e0_same", rdata[31:0], 32'd0);
    step();
    clear_inputs();
    #1;
    check("t4_rd_e0_next", rdata[31:0], 32'd0);
    step();

    // Same-cycle write visibility on read port (bypass-dependent)
    clear_inputs();
    set_write(1, 3, 32'h55);
    set_raddr(3, 0, 0, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("tb_rd_e3_same", rdata[31:0], 32'h55);
`else
    check("tb_rd_e3_same", rdata[31:0], 32'd3);
`endif
    step();
    clear_inputs();
    set_raddr(3, 0, 0, 0);
    #1;
    check("tb_rd_e3_next", rdata[31:0], 32'h55);
    step();

    // Full dump with toggling ready and a stray start mid-dump
    do_reset();
    check("t5_err_after_reset", 32'(err_wconf), 32'd0);
    beat_addr.delete();
    beat_last.delete();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      dump_ready = (c % 2 == 0);
      dump_start = (c == 20);
      step();
      if (!dump_busy) done = 1'b1;
    end
    dump_start = 1'b0;
    dump_ready = 1'b0;
    check("t5_done", 32'(done), 32'd1);
    check("t5_beats", 32'(beat_addr.size()), 32'(N_ENTRY));
    for (int i = 0; i < beat_addr.size(); i++) begin
      check($sformatf("t5_beat%0d_addr", i), 32'(beat_addr[i]), 32'(i));
      check($sformatf("t5_beat%0d_last", i), 32'(beat_last[i]), 32'(i == N_ENTRY - 1));
    end
    step();

    // Reset asserted while the dump sits on beat 10
    clear_inputs();
    set_write(0, 12, 32'hCAFE);
    step();
    clear_inputs();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (dump_addr == W_ADDR'(10)) done = 1'b1;
      else step();
    end
    check("t6_reached_beat10", 32'(done), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid_async", 32'(dump_valid), 32'd0);
    check("t6_busy_async",  32'(dump_busy),  32'd0);
    check("t6_addr_async",  32'(dump_addr),  32'd0);
    model_reset();
    clear_inputs();
    set_raddr(12, 5, 9, 7);
    #1;
    check("t6_rd_e12", rdata[31:0],   32'd12);
    check("t6_rd_e5",  rdata[63:32],  32'd5);
    check("t6_rd_e9",  rdata[95:64],  32'd9);
    check("t6_rd_e7",  rdata[127:96], 32'd7);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Randomized traffic with concurrent dumps
    beat_addr.delete();
    beat_last.delete();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N_WPORT; p++) begin
        r = $urandom_range(0, 19);
        v = '0;
        if (r >= 8) v[$urandom_range(0, N_ENTRY - 1)] = 1'b1;
        if (r == 19) v[$urandom_range(0, N_ENTRY - 1)] = 1'b1;
        wen_onehot[p*N_ENTRY +: N_ENTRY] = v;
        wdata[p*W_DATA +: W_DATA]        = $urandom();
      end
      for (int k = 0; k < N_RPORT; k++)
        raddr[k*W_ADDR +: W_ADDR] = W_ADDR'($urandom_range(0, N_ENTRY - 1));
      dump_start = ($urandom_range(0, 19) == 0);
      dump_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
